// File: rtl/serial_sub_if.sv
// Handshake/result bundle for serial_sub; the ovf signal exists only when
// SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
    parameter int N = 8
);
    // Handshake: start is sampled on a rising edge only while busy=0, and the
    // operands and bin are captured on that same edge. busy is high from the
    // following cycle until completion. done pulses for one cycle, and from
    // then on d/bout (and ovf) hold their value until the next completion.
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif
    logic         state_dbg;  // 1 while the FSM is in RUN

`ifdef SERIAL_SUB_OVF_EN
    modport master (output start, a, b, bin,
                    input  busy, done, d, bout, ovf, state_dbg);
    modport slave  (input  start, a, b, bin,
                    output busy, done, d, bout, ovf, state_dbg);
`else
    modport master (output start, a, b, bin,
                    input  busy, done, d, bout, state_dbg);
    modport slave  (input  start, a, b, bin,
                    output busy, done, d, bout, state_dbg);
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor (a - b - bin), LSB first, one full-subtractor cell.
// Optional signed-overflow output is enabled with SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  d_sh_q, d_sh_d;
    logic          br_q, br_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  d_q, d_d;
    logic          bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    logic x, y, diff, br_new;

    always_comb begin
        x      = a_sh_q[0];
        y      = b_sh_q[0];
        diff   = x ^ y ^ br_q;
        br_new = (~x & y) | (~(x ^ y) & br_q);

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        d_d     = d_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    br_d    = bus.bin;
                    d_sh_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = {1'b0, a_sh_q[N-1:1]};
                b_sh_d = {1'b0, b_sh_q[N-1:1]};
                d_sh_d = {diff, d_sh_q[N-1:1]};
                br_d   = br_new;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Results are published only here, so d/bout never show partial work.
                    d_d     = {diff, d_sh_q[N-1:1]};
                    bout_d  = br_new;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = br_q ^ br_new;
`endif
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
    assign bus.state_dbg = (state_q == RUN);

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: N=8 directed/random ops plus an N=4 sweep.
module tb_serial_sub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    serial_sub_if #(.N(8)) bus8 ();
    serial_sub_if #(.N(4)) bus4 ();

    serial_sub #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_sub #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // scoreboards: {ovf, bout, d}
    logic [9:0] exp8_q[$];
    logic [5:0] exp4_q[$];
    logic       prev_done8 = 1'b0;
    logic       prev_done4 = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, bout, d} for width n.
    function automatic logic [63:0] model(input int n, input int a, input int b, input int bin);
        int full, sa, sb, r, half;
        logic [63:0] res;
        half = 1 << (n - 1);
        full = a - b - bin;
        res = 64'(full & ((1 << n) - 1));
        res[n] = (full < 0);
        sa = (a >= half) ? a - 2 * half : a;
        sb = (b >= half) ? b - 2 * half : b;
        r  = sa - sb - bin;
        res[n+1] = (r < -half) || (r > half - 1);
        return res;
    endfunction

    always @(negedge clk) begin
        logic [9:0] e;
        if (bus8.done) begin
            check("done8_pulse", 64'(prev_done8), 64'(0));
            if (exp8_q.size() == 0) begin
                check("done8_unexpected", 64'(bus8.done), 64'(0));
            end else begin
                e = exp8_q.pop_front();
                check("d8", 64'(bus8.d), 64'(e[7:0]));
                check("bout8", 64'(bus8.bout), 64'(e[8]));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf8", 64'(bus8.ovf), 64'(e[9]));
`endif
            end
        end
        prev_done8 = bus8.done;
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (bus4.done) begin
            check("done4_pulse", 64'(prev_done4), 64'(0));
            if (exp4_q.size() == 0) begin
                check("done4_unexpected", 64'(bus4.done), 64'(0));
            end else begin
                e = exp4_q.pop_front();
                check("sum4", 64'({bus4.bout, bus4.d}), 64'(e[4:0]));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf4", 64'(bus4.ovf), 64'(e[5]));
`endif
            end
        end
        prev_done4 = bus4.done;
    end

    // driver tasks
    task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic bin, output int k);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a = a;
        bus8.b = b;
        bus8.bin = bin;
        exp8_q.push_back(10'(model(8, int'(a), int'(b), int'(bin))));
        @(posedge clk);
        #1;
        k = edge_cnt;
        bus8.start = 1'b0;
        bus8.a = 8'($urandom_range(0, 255));
        bus8.b = 8'($urandom_range(0, 255));
        bus8.bin = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done8(input int budget);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus8.done && cyc < budget);
        if (!bus8.done) check("timeout8", 64'(bus8.done), 64'(1));
    endtask

    task automatic op4(input int a, input int b, input int bin);
        int cyc;
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a = 4'(a);
        bus4.b = 4'(b);
        bus4.bin = 1'(bin);
        exp4_q.push_back(6'(model(4, a, b, bin)));
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus4.done && cyc < 10);
        if (!bus4.done) check("timeout4", 64'(bus4.done), 64'(1));
    endtask

    logic [7:0] tab_a[4] = '{8'h12, 8'h00, 8'h80, 8'h7F};
    logic [7:0] tab_b[4] = '{8'h35, 8'h00, 8'h01, 8'hFF};
    logic       tab_c[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int k, t1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;

        // reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", 64'(bus8.busy), 64'(0));
            check("idle_done", 64'(bus8.done), 64'(0));
            check("idle_d", 64'(bus8.d), 64'(0));
            check("idle_bout", 64'(bus8.bout), 64'(0));
        end

        // basic op with cycle-accurate busy/done
        start_op8(8'h35, 8'h12, 1'b0, k);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("run_busy", 64'(bus8.busy), 64'(1));
            check("run_done", 64'(bus8.done), 64'(0));
            check("run_state", 64'(bus8.state_dbg), 64'(1));
        end
        @(negedge clk);
        check("end_busy", 64'(bus8.busy), 64'(0));
        check("end_done", 64'(bus8.done), 64'(1));
        check("latency", 64'(edge_cnt - k), 64'(8));
        @(negedge clk);
        check("done_drop", 64'(bus8.done), 64'(0));
        check("d_hold", 64'(bus8.d), 64'(8'h23));

        // directed table
        for (int i = 0; i < 4; i++) begin
            start_op8(tab_a[i], tab_b[i], tab_c[i], k);
            wait_done8(20);
        end

        // start while busy is ignored
        start_op8(8'h35, 8'h12, 1'b0, k);
        repeat (3) @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00; bus8.bin = 1'b0;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        wait_done8(20);
        check("ignored_latency", 64'(edge_cnt - k), 64'(8));

        // start held through the done cycle launches back-to-back op
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h35; bus8.b = 8'h12; bus8.bin = 1'b0;
        exp8_q.push_back(10'(model(8, 'h35, 'h12, 0)));
        @(posedge clk);
        #1;
        bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.bin = 1'b1;
        exp8_q.push_back(10'(model(8, 'h5A, 'h3C, 1)));
        wait_done8(20);
        t1 = edge_cnt;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        wait_done8(20);
        check("b2b_spacing", 64'(edge_cnt - t1), 64'(9));

        // reset mid-run aborts
        start_op8(8'h35, 8'h12, 1'b0, k);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp8_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(bus8.busy), 64'(0));
        check("abort_d", 64'(bus8.d), 64'(0));
        check("abort_bout", 64'(bus8.bout), 64'(0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(bus8.done), 64'(0));
        end
        start_op8(8'h35, 8'h12, 1'b0, k);
        wait_done8(20);

        // random N=8 ops
        for (int i = 0; i < 20; i++) begin
            start_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), k);
            wait_done8(20);
        end

        // exhaustive N=4 sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op4(a, b, c);

        repeat (3) @(negedge clk);
        check("sb8_empty", 64'(exp8_q.size()), 64'(0));
        check("sb4_empty", 64'(exp4_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
Bit-serial N-bit subtractor that computes a - b - bin, one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow, and is the subtraction counterpart of the team's full-adder cell. It is controlled by a start/busy/done handshake and is used in lab datapaths where area matters more than latency.

Parameters:
N, 8, operand and result width in bits (N >= 2).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when busy=0
a  input  N  minuend; captured on accepted start
b  input  N  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when d/bout become valid
d  output  N  difference a - b - bin (mod 2^N)
bout  output  1  borrow-out of the MSB (1 means a < b + bin, unsigned)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a rising edge with rst=1:
  - FSM goes to IDLE.
  - busy=0, done=0, d=0, bout=0.
  - Internal shift registers, borrow register and bit counter are cleared.
  - rst has priority over every other input.
- FSM states: IDLE, RUN.
- IDLE:
  - On an edge with start=1, capture a, b and bin into internal shift registers and the borrow register.
  - Counter is set to 0, next state is RUN, busy=1 from the following cycle.
  - start=0 keeps the FSM in IDLE.
- RUN, on each edge:
  - Process bit i = counter, with x = a_sh[0], y = b_sh[0], br = borrow register.
  - Difference bit = x ^ y ^ br.
  - New borrow = (~x & y) | (~(x ^ y) & br).
  - The difference bit is shifted into d_sh from the MSB side; a_sh and b_sh shift right; the borrow register updates; the counter increments.
- RUN exit, on the edge where counter = N-1:
  - Next state is IDLE; busy=0.
  - done=1 for exactly the next cycle.
  - d = completed difference; bout = final borrow.
- Latency: start accepted at edge k; done=1 and results valid after edge k+N. Throughput is one operation per N+1 cycles.
- d and bout hold their value from done until the next completion. They do not change during RUN; the working register is internal.
- start while busy=1 is ignored, with no effect on operands or timing.
- start=1 in the done cycle is accepted, because the FSM is in IDLE; done still deasserts on the next edge.
- Operands a, b, bin may change freely after capture.
- Reset mid-RUN aborts the operation: no done pulse, and outputs take their reset values.
- Counter width is $clog2(N); no wrap occurs because the FSM exits at N-1.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, updated together with d/bout on completion and held like them.
  - ovf = (borrow into MSB cell) ^ (borrow out of MSB cell), i.e. signed two's-complement overflow of a - b - bin.
  - The borrow into the MSB is registered during bit N-1.
- Not defined:
  - ovf port and its logic are absent.
  - Port list and all other behaviour are identical.

Test Plan:
1. rst=1 for 2 edges, then rst=0 -> busy=0, done=0, d=0x00, bout=0. Hold start=0 for 5 cycles -> outputs unchanged.
2. N=8, a=0x35, b=0x12, bin=0, start pulse at edge k -> busy=1 for edges k+1..k+8. done=1 exactly one cycle after edge k+8 with d=0x23, bout=0 (ovf=0).
3. a=0x12, b=0x35, bin=0 -> d=0xDD, bout=1 (ovf=0). Then a=0x00, b=0x00, bin=1 -> d=0xFF, bout=1.
4. a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0, ovf=1 when SERIAL_SUB_OVF_EN is defined. a=0x7F, b=0xFF -> d=0x80, bout=1, ovf=1.
5. Start 0x35-0x12; at edge k+3 assert start with a=0xFF, b=0x00 -> ignored; result d=0x23 at edge k+8. A start held high through the done cycle launches a second operation that completes N+1 cycles later.
6. Start 0x35-0x12; assert rst at edge k+4 -> no done pulse; busy=0, d=0x00, bout=0. A new start after reset yields a correct result.
7. Exhaustive sweep for N=4 (all a, b, bin) -> {bout, d} == (a - b - bin) mod 32 for every case.
